// File: rtl/pin_keyer_if.sv
// pin_keyer_if: PIN request in, button presses and status out; abort_i exists only with PIN_KEYER_ABORT_EN
interface pin_keyer_if #(
    parameter int N_DIGITS = 4
);
    logic                  start_i;
    logic [4*N_DIGITS-1:0] pin_vec_i;
    logic                  b_dir_o;
    logic                  b_esq_o;
    logic                  busy_o;
    logic                  done_o;
    logic                  err_o;
`ifdef PIN_KEYER_ABORT_EN
    logic                  abort_i;
    modport master (output start_i, pin_vec_i, abort_i, input b_dir_o, b_esq_o, busy_o, done_o, err_o);
    modport slave  (input start_i, pin_vec_i, abort_i, output b_dir_o, b_esq_o, busy_o, done_o, err_o);
`else
    modport master (output start_i, pin_vec_i, input b_dir_o, b_esq_o, busy_o, done_o, err_o);
    modport slave  (input start_i, pin_vec_i, output b_dir_o, b_esq_o, busy_o, done_o, err_o);
`endif
endinterface

// File: rtl/pin_keyer.sv
// pin_keyer: replays a stored PIN as b_dir/b_esq presses; PIN_KEYER_ABORT_EN adds the abort_i input
module pin_keyer #(
    parameter int PULSE_CYC = 10,
    parameter int GAP_CYC   = 10,
    parameter int DIGIT_MAX = 9,
    parameter int N_DIGITS  = 4
) (
    input logic        clk_i,
    input logic        rst_i,
    pin_keyer_if.slave bus
);
    localparam int TMAX = PULSE_CYC > GAP_CYC ? PULSE_CYC : GAP_CYC;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int IW   = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
    localparam int PW   = 4 * N_DIGITS;

    typedef enum logic [2:0] {IDLE, CHECK, INC_HI, INC_LO, SEL_HI, SEL_LO, DONE} state_t;

    state_t        state, nxt;
    logic [PW-1:0] pin;
    logic [IW-1:0] idx;
    logic [3:0]    rem, cur_d, nxt_d;
    logic [TW-1:0] tmr;
    logic          bad, ab, last, p_end, g_end;
    logic          dir_n, esq_n, busy_n, done_n, err_n;

`ifdef PIN_KEYER_ABORT_EN
    assign ab = bus.abort_i;
`else
    assign ab = 1'b0;
`endif

    assign cur_d = 4'(pin >> (4 * idx));
    assign nxt_d = 4'(pin >> (4 * idx + 4));
    assign last  = idx == IW'(N_DIGITS - 1);
    assign p_end = tmr == TW'(PULSE_CYC - 1);
    assign g_end = tmr == TW'(GAP_CYC - 1);

    // a single out-of-range digit rejects the whole PIN before anything is pressed
    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) bad = bad | (pin[4*i +: 4] > 4'(DIGIT_MAX));
    end

    // state register
    always_ff @(posedge clk_i) state <= rst_i ? IDLE : nxt;

    // next state: press/gap phases per digit, abort always falls back to IDLE
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = bus.start_i ? CHECK : IDLE;
            CHECK:   nxt = bad ? IDLE : (cur_d != 4'd0 ? INC_HI : SEL_HI);
            INC_HI:  nxt = p_end ? INC_LO : INC_HI;
            INC_LO:  nxt = g_end ? (rem > 4'd1 ? INC_HI : SEL_HI) : INC_LO;
            SEL_HI:  nxt = p_end ? SEL_LO : SEL_HI;
            SEL_LO:  nxt = g_end ? (last ? DONE : (nxt_d != 4'd0 ? INC_HI : SEL_HI)) : SEL_LO;
            default: nxt = IDLE;
        endcase
        if (ab) nxt = IDLE;
    end

    // datapath: PIN latch while idle, digit index, remaining increments, phase timer
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pin <= '0;
            idx <= '0;
            rem <= '0;
            tmr <= '0;
        end else begin
            tmr <= (nxt != state) ? '0 : tmr + 1'b1;
            if (state == IDLE) begin
                pin <= bus.pin_vec_i;
                idx <= '0;
            end
            if (state == CHECK) rem <= cur_d;
            if (state == INC_LO && g_end) rem <= rem - 4'd1;
            if (state == SEL_LO && g_end && !last) begin
                idx <= idx + 1'b1;
                rem <= nxt_d;
            end
        end
    end

    // output decode; busy covers acceptance through the last gap and drops with done/err
    always_comb begin
        dir_n  = state == INC_HI && !ab;
        esq_n  = state == SEL_HI && !ab;
        done_n = state == DONE && !ab;
        err_n  = state == CHECK && bad && !ab;
        busy_n = !ab && (state == IDLE ? bus.start_i : !(state == DONE || (state == CHECK && bad)));
    end

    // registered outputs so button lines never glitch
    always_ff @(posedge clk_i) begin
        if (rst_i) {bus.b_dir_o, bus.b_esq_o, bus.busy_o, bus.done_o, bus.err_o} <= '0;
        else {bus.b_dir_o, bus.b_esq_o, bus.busy_o, bus.done_o, bus.err_o} <= {dir_n, esq_n, busy_n, done_n, err_n};
    end
endmodule
